// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller: stack pointer, data-memory req/ack, MEM/WB register
// Optional stack bounds checking is enabled by defining SP_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter logic [31:0] SP_INIT  = 32'h0000_FFFC,
    parameter logic [31:0] SP_LIMIT = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] wr_data,
    input  logic [3:0]  reg_dst,
    input  logic [31:0] pc_plus4,
    input  logic        reg_wr,
    input  logic        wb_sel,
    input  logic        mem_addr_sel,
    input  logic        mem_wr,
    input  logic [1:0]  sp_select,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_out,
    output logic [31:0] sp_out,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_reg_dst,
    output logic [31:0] wb_pc_plus4,
    output logic        wb_reg_wr,
    output logic        sp_fault
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [31:0] sp;
    logic [31:0] addr_sel;
    logic [31:0] sp_next;
    logic        access;
    logic        fault;
    logic        go;
    logic        is_load;
    logic        complete;

    always_comb begin
        access = mem_wr | wb_sel | (mem_addr_sel & (sp_select != 2'b00));
        is_load = wb_sel & ~mem_wr;

        if (!mem_addr_sel)
            addr_sel = alu_out;
        else if (sp_select == 2'b01)
            addr_sel = sp - 32'd4;
        else
            addr_sel = sp;

        case (sp_select)
            2'b01:   sp_next = sp - 32'd4;
            2'b10:   sp_next = sp + 32'd4;
            default: sp_next = sp;
        endcase
    end

`ifdef SP_BOUNDS_CHECK_EN
    // A faulting stack op is resolved in IDLE without ever touching memory.
    assign fault = (state == IDLE) &&
                   (((sp_select == 2'b01) && (sp == SP_LIMIT)) ||
                    ((sp_select == 2'b10) && (sp == SP_INIT)));

    always_ff @(posedge clk) begin
        if (rst)
            sp_fault <= 1'b0;
        else if (fault)
            sp_fault <= 1'b1;
    end
`else
    wire unused_sp_limit = ^SP_LIMIT;
    assign fault    = 1'b0;
    assign sp_fault = 1'b0;
`endif

    assign go        = access & ~fault;
    assign complete  = ((state == IDLE) && !go) || ((state == ACCESS) && dm_ack);
    assign stall_out = !rst && (((state == IDLE) && go) || ((state == ACCESS) && !dm_ack));
    assign sp_out    = sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_wdata    <= 32'd0;
            wb_data     <= 32'd0;
            wb_reg_dst  <= 4'd0;
            wb_pc_plus4 <= 32'd0;
            wb_reg_wr   <= 1'b0;
            sp          <= SP_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        dm_req   <= 1'b1;
                        dm_we    <= mem_wr;
                        dm_addr  <= addr_sel;
                        dm_wdata <= wr_data;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // EX/MEM inputs are frozen by the stall, so they are still valid here.
            if (complete) begin
                wb_data     <= ((state == ACCESS) && is_load) ? dm_rdata : alu_out;
                wb_reg_dst  <= reg_dst;
                wb_pc_plus4 <= pc_plus4;
                wb_reg_wr   <= reg_wr & ~fault;
                if (!fault)
                    sp <= sp_next;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - vector table plus scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam logic [31:0] SP_INIT  = 32'h0000_FFFC;
    localparam logic [31:0] SP_LIMIT = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, wr_data, pc_plus4, dm_rdata;
    logic [3:0]  reg_dst;
    logic        reg_wr, wb_sel, mem_addr_sel, mem_wr, dm_ack;
    logic [1:0]  sp_select;
    logic        dm_req, dm_we, stall_out, wb_reg_wr, sp_fault;
    logic [31:0] dm_addr, dm_wdata, sp_out, wb_data, wb_pc_plus4;
    logic [3:0]  wb_reg_dst;

    mem_access_ctrl #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .wr_data(wr_data), .reg_dst(reg_dst),
        .pc_plus4(pc_plus4), .reg_wr(reg_wr), .wb_sel(wb_sel), .mem_addr_sel(mem_addr_sel),
        .mem_wr(mem_wr), .sp_select(sp_select), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall_out(stall_out), .sp_out(sp_out), .wb_data(wb_data), .wb_reg_dst(wb_reg_dst),
        .wb_pc_plus4(wb_pc_plus4), .wb_reg_wr(wb_reg_wr), .sp_fault(sp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, wdata, pc;
        logic [3:0]  rd;
        logic        reg_wr, wb_sel, mas, mem_wr;
        logic [1:0]  sps;
        int          wait_n;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] data, pc, sp;
        logic [3:0]  rd;
        logic        reg_wr;
    } exp_t;

    exp_t        sb[$];
    vec_t        table_v[7];
    logic [31:0] sp_m;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] pc,
                                input logic [3:0] rd, input logic rw, input logic ws, input logic mas,
                                input logic mw, input logic [1:0] sps, input int wait_n,
                                input logic [31:0] rdata);
        vec_t v;
        v.alu = alu; v.wdata = wdata; v.pc = pc; v.rd = rd; v.reg_wr = rw; v.wb_sel = ws;
        v.mas = mas; v.mem_wr = mw; v.sps = sps; v.wait_n = wait_n; v.rdata = rdata;
        return v;
    endfunction

    function automatic logic is_fault(input logic [1:0] sps, input logic [31:0] sp);
`ifdef SP_BOUNDS_CHECK_EN
        return ((sps == 2'b01) && (sp == SP_LIMIT)) || ((sps == 2'b10) && (sp == SP_INIT));
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_bubble();
        alu_out = 0; wr_data = 0; pc_plus4 = 0; reg_dst = 0; reg_wr = 0; wb_sel = 0;
        mem_addr_sel = 0; mem_wr = 0; sp_select = 0; dm_ack = 0; dm_rdata = 0;
    endtask

    // Called #1 after a rising edge; returns #1 after the completion edge.
    task automatic run(input vec_t v);
        exp_t        e, got;
        logic        acc, flt, ld;
        logic [31:0] addr;
        int          stalls;
        acc  = v.mem_wr | v.wb_sel | (v.mas && (v.sps != 2'b00));
        flt  = is_fault(v.sps, sp_m);
        ld   = v.wb_sel & ~v.mem_wr;
        addr = !v.mas ? v.alu : ((v.sps == 2'b01) ? sp_m - 32'd4 : sp_m);
        e.data   = (acc && !flt && ld) ? v.rdata : v.alu;
        e.rd     = v.rd;
        e.pc     = v.pc;
        e.reg_wr = v.reg_wr & ~flt;
        e.sp     = flt ? sp_m : ((v.sps == 2'b01) ? sp_m - 32'd4 :
                                 (v.sps == 2'b10) ? sp_m + 32'd4 : sp_m);
        sb.push_back(e);

        alu_out = v.alu; wr_data = v.wdata; pc_plus4 = v.pc; reg_dst = v.rd; reg_wr = v.reg_wr;
        wb_sel = v.wb_sel; mem_addr_sel = v.mas; mem_wr = v.mem_wr; sp_select = v.sps;
        dm_ack = 0; dm_rdata = ~v.rdata;
        #1;
        stalls = 0;
        if (acc && !flt) begin
            if (stall_out) stalls++;
            @(posedge clk); #1;
            check("dm_req_set", {31'd0, dm_req}, 32'd1);
            check("dm_addr", dm_addr, addr);
            check("dm_we", {31'd0, dm_we}, {31'd0, v.mem_wr});
            if (v.mem_wr) check("dm_wdata", dm_wdata, v.wdata);
            for (int i = 0; i < v.wait_n; i++) begin
                if (stall_out) stalls++;
                @(posedge clk); #1;
                check("dm_addr_held", dm_addr, addr);
            end
            dm_ack = 1; dm_rdata = v.rdata; #1;
            check("stall_on_ack", {31'd0, stall_out}, 32'd0);
            @(posedge clk); #1;
            dm_ack = 0; dm_rdata = 0;
            check("stall_cycles", stalls, 1 + v.wait_n);
        end else begin
            check("stall_none", {31'd0, stall_out}, 32'd0);
            @(posedge clk); #1;
        end
        check("dm_req_clear", {31'd0, dm_req}, 32'd0);
        got = sb.pop_front();
        check("wb_data", wb_data, got.data);
        check("wb_reg_dst", {28'd0, wb_reg_dst}, {28'd0, got.rd});
        check("wb_pc_plus4", wb_pc_plus4, got.pc);
        check("wb_reg_wr", {31'd0, wb_reg_wr}, {31'd0, got.reg_wr});
        check("sp_out", sp_out, got.sp);
        sp_m = got.sp;
    endtask

    initial begin
        table_v[0] = mk(32'h1234, 0, 32'h100, 4'd3, 1, 0, 0, 0, 2'b00, 0, 0);
        table_v[1] = mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 2'b00, 0, 0);
        table_v[2] = mk(32'h40, 0, 32'h104, 4'd5, 1, 1, 0, 0, 2'b00, 3, 32'hCAFE_0001);
        table_v[3] = mk(32'h80, 32'h1122_3344, 32'h108, 4'd0, 0, 0, 0, 1, 2'b00, 0, 0);
        table_v[4] = mk(32'h84, 32'h5566_7788, 32'h10C, 4'd7, 1, 1, 0, 1, 2'b00, 1, 32'hFFFF);
        table_v[5] = mk(32'h44, 0, 32'h110, 4'd9, 1, 1, 0, 0, 2'b00, 0, 32'h0BAD_F00D);
        table_v[6] = mk(32'hFFFF_FFFF, 0, 32'h114, 4'd15, 0, 0, 0, 0, 2'b00, 0, 0);

        drive_bubble();
        alu_out = 32'h40; wb_sel = 1;
        rst = 1;
        #1;
        check("stall_in_reset", {31'd0, stall_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        drive_bubble();
        sp_m = SP_INIT;
        check("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
        check("rst_sp", sp_out, 32'h0000_FFFC);
        check("rst_sp_fault", {31'd0, sp_fault}, 32'd0);

        for (int i = 0; i < 7; i++) run(table_v[i]);

        // Push then pop through the stack pointer.
        run(mk(32'h9999, 32'hDEAD_BEEF, 32'h200, 4'd0, 0, 0, 1, 1, 2'b01, 0, 0));
        check("push_sp", sp_out, 32'h0000_FFF8);
        run(mk(32'h0, 0, 32'h204, 4'd4, 1, 1, 1, 0, 2'b10, 0, 32'hDEAD_BEEF));
        check("pop_sp", sp_out, 32'h0000_FFFC);
        check("pop_data", wb_data, 32'hDEAD_BEEF);
        run(mk(32'h0, 0, 32'h208, 4'd6, 1, 1, 1, 0, 2'b11, 2, 32'h7777_0000));

        // Reset in the middle of an access.
        run(mk(32'h0, 32'h1, 32'h20C, 4'd0, 0, 0, 1, 1, 2'b01, 0, 0));
        alu_out = 32'h200; wb_sel = 1; reg_wr = 1; reg_dst = 4'd2; pc_plus4 = 32'h210;
        #1;
        @(posedge clk); #1;
        check("mid_dm_req", {31'd0, dm_req}, 32'd1);
        rst = 1; #1;
        check("mid_stall_rst", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        drive_bubble();
        sp_m = SP_INIT;
        check("mid_dm_req_drop", {31'd0, dm_req}, 32'd0);
        check("mid_sp", sp_out, 32'h0000_FFFC);
        check("mid_wb_data", wb_data, 32'd0);
        check("mid_wb_reg_dst", {28'd0, wb_reg_dst}, 32'd0);
        check("mid_wb_pc", wb_pc_plus4, 32'd0);
        check("mid_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
        dm_ack = 1; dm_rdata = 32'h0000_0BAD; #1;
        check("late_ack_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        dm_ack = 0; dm_rdata = 0;
        check("late_ack_req", {31'd0, dm_req}, 32'd0);
        check("late_ack_wb", wb_data, 32'd0);

        // Pop on an empty stack.
        run(mk(32'h0, 0, 32'h300, 4'd8, 1, 1, 1, 0, 2'b10, 0, 32'h1357_9BDF));
`ifdef SP_BOUNDS_CHECK_EN
        check("empty_pop_sp", sp_out, 32'h0000_FFFC);
        check("empty_pop_fault", {31'd0, sp_fault}, 32'd1);
        run(table_v[0]);
        check("fault_sticky", {31'd0, sp_fault}, 32'd1);
`else
        check("empty_pop_sp", sp_out, 32'h0001_0000);
        check("empty_pop_fault", {31'd0, sp_fault}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
